seg_scan: RTL and testbench

Time-multiplexed seven-segment display controller. Holds an NDIG-digit hex frame in a double buffer, scans one digit position at a time through a shared hex-to-segment decoder, and drives active-low anode selects and active-low segments with inter-digit blanking to suppress ghosting. Sits between the datapath (shift register, counters) and the board display pins; producers hand it new frames through a valid/ready write port.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_scan_if.sv | 15 +
 rtl/seg_scan_hex7seg.sv | 9 +
 rtl/seg_scan.sv | 111 +++++++++++
 tb/tb_seg_scan.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns,
// blank pattern, slot phase type and a parameter sanity check.
package seg_pkg;

  // Segments a..g on bits 6..0, active low.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  function automatic bit params_ok(input int unsigned ndig,
                                   input int unsigned div,
                                   input int unsigned blank);
    return (div > blank) && (blank >= 1) && (ndig >= 2) && (ndig <= 8);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Frame write port: producer offers {data, mask, lz} under valid/ready.
interface seg_scan_if #(
  parameter int unsigned NDIG = 8
);
  logic                wr_valid;
  logic                wr_ready;
  logic [4*NDIG-1:0]   wr_data;
  logic [NDIG-1:0]     wr_mask;
  logic                lz_en;

  modport master (output wr_valid, output wr_data, output wr_mask, output lz_en,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, input  wr_mask, input  lz_en,
                  output wr_ready);
endinterface

// File: rtl/seg_scan_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment controller: double-buffered hex frame,
// one digit per slot, blanking at slot start, shared decoder.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned NDIG  = 8,
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_if.slave       wr,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg,
  output logic            frame_done
);

  localparam int unsigned DW = $clog2(NDIG);
  localparam int unsigned CW = $clog2(DIV);
  localparam logic [DW-1:0] D_LAST = DW'(NDIG - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_BLK_END = CW'(BLANK - 1);

  if (!params_ok(NDIG, DIV, BLANK)) begin : g_bad_params
    $fatal(1, "seg_scan: need DIV > BLANK >= 1 and 2 <= NDIG <= 8");
  end

  logic [NDIG-1:0][3:0] sh_data, act_data;
  logic [NDIG-1:0]      sh_mask, act_mask;
  logic                 sh_lz, act_lz;
  logic                 pending;
  logic [DW-1:0]        d;
  logic [CW-1:0]        cnt;
  phase_t               phase;
  logic [NDIG-1:0]      visible;
  logic [6:0]           dec;
  logic                 wrap;

  assign wr.wr_ready = !pending;
  assign wrap        = (d == D_LAST) && (cnt == C_LAST);

  // Scan from the top digit down; suppression holds until the first
  // enabled non-zero digit. Digit 0 always survives.
  always_comb begin : suppress
    logic lead;
    visible = '0;
    lead    = act_lz;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (act_mask[DW'(NDIG-1-k)] && (act_data[DW'(NDIG-1-k)] != 4'h0))
        lead = 1'b0;
      visible[DW'(NDIG-1-k)] = act_mask[DW'(NDIG-1-k)] && (!lead || (k == NDIG-1));
    end
  end

  hex7seg u_dec (
    .nib (act_data[d]),
    .seg (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data    <= '0;
      sh_mask    <= '0;
      sh_lz      <= 1'b0;
      act_data   <= '0;
      act_mask   <= '0;
      act_lz     <= 1'b0;
      pending    <= 1'b0;
      d          <= '0;
      cnt        <= '0;
      phase      <= PH_BLANK;
      an         <= '1;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      if (wr.wr_valid && !pending) begin
        sh_data <= wr.wr_data;
        sh_mask <= wr.wr_mask;
        sh_lz   <= wr.lz_en;
        pending <= 1'b1;
      end

      // phase mirrors (cnt < BLANK) one step ahead so it is valid in-cycle
      if (cnt == C_LAST) begin
        cnt   <= '0;
        phase <= PH_BLANK;
        d     <= (d == D_LAST) ? '0 : d + 1'b1;
        if (wrap && pending) begin
          act_data <= sh_data;
          act_mask <= sh_mask;
          act_lz   <= sh_lz;
          pending  <= 1'b0;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == C_BLK_END) phase <= PH_SHOW;
      end

      frame_done <= wrap;

      if ((phase == PH_SHOW) && visible[d]) begin
        an  <= ~(NDIG'(1) << d);
        seg <= dec;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: randomized frame writes checked cycle by
// cycle against a time-indexed behavioural display model.
module tb_seg_scan;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;
  localparam int          FR    = NDIG * DIV;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mask;
    logic        lz;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  seg_scan_if #(.NDIG(NDIG)) wr ();

  seg_scan #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected glyphs for 0..F.
  logic [6:0] segs [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int     vectors = 0;
  int     errs    = 0;
  int     n       = -1;   // cycle index since last reset edge
  int     fd_cnt  = 0;
  frame_t act_f   = '{16'h0, 4'h0, 1'b0};
  frame_t pend_q [$];
  frame_t hs_frame;
  bit     hs_prev = 1'b0;

  task automatic chk(input string nm, input int a, input int e);
    vectors++;
    if (a != e) begin
      errs++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, n, a, e);
    end
  endtask

  function automatic logic [3:0] nib(input frame_t f, input int dg);
    return 4'(f.data >> (4 * dg));
  endfunction

  function automatic bit on(input frame_t f, input int dg);
    int top;
    if (((f.mask >> dg) & 4'h1) == 4'h0) return 1'b0;
    if (!f.lz || dg == 0) return 1'b1;
    top = -1;
    for (int j = 0; j < NDIG; j++)
      if ((((f.mask >> j) & 4'h1) != 4'h0) && nib(f, j) != 4'h0) top = j;
    return dg <= top;
  endfunction

  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_fd;
  int         m, dd, cc;

  always @(negedge clk) begin
    if (n >= 0) begin
      e_an  = '1;
      e_seg = 7'h7F;
      e_fd  = 1'b0;
      if (n > 0) begin
        m  = n - 1;
        dd = (m / DIV) % NDIG;
        cc = m % DIV;
        e_fd = (m % FR) == (FR - 1);
        if (cc >= BLANK && on(act_f, dd)) begin
          e_an  = ~(4'b0001 << dd);
          e_seg = segs[nib(act_f, dd)];
        end
      end
      chk("an", int'(an), int'(e_an));
      chk("seg", int'(seg), int'(e_seg));
      chk("frame_done", int'(frame_done), int'(e_fd));
      if (n >= 1 && n <= 320 && frame_done) fd_cnt++;

      if (n > 0 && (n % FR) == 0 && pend_q.size() > 0) act_f = pend_q.pop_front();
      if (hs_prev) pend_q.push_back(hs_frame);
      chk("wr_ready", int'(wr.wr_ready), int'(pend_q.size() == 0));
      hs_prev  = wr.wr_valid && (pend_q.size() == 0);
      hs_frame = '{wr.wr_data, wr.wr_mask, wr.lz_en};
    end
    if (rst) begin
      n       = 0;
      act_f   = '{16'h0, 4'h0, 1'b0};
      pend_q.delete();
      hs_prev = 1'b0;
      fd_cnt  = 0;
    end else if (n >= 0) begin
      n++;
    end
  end

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [15:0] dt, input logic [3:0] mk, input logic lz);
    bit took;
    int guard;
    wr.wr_valid = 1'b1;
    wr.wr_data  = dt;
    wr.wr_mask  = mk;
    wr.lz_en    = lz;
    took  = 1'b0;
    guard = 0;
    while (!took) begin
      @(negedge clk);
      took = wr.wr_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!took && guard > 3 * FR) begin
        vectors++;
        errs++;
        $display("FAIL write_accept timeout: got no ready in %0d cycles, required acceptance", guard);
        break;
      end
    end
    wr.wr_valid = 1'b0;
    wr.wr_data  = 16'($urandom);
    wr.wr_mask  = 4'($urandom);
    wr.lz_en    = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr.wr_valid = 1'b0;
    wr.wr_data  = '0;
    wr.wr_mask  = '0;
    wr.lz_en    = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(40);

    write_frame(16'h12AF, 4'hF, 1'b0);
    idle(2 * FR);
    write_frame(16'h0050, 4'hF, 1'b1);
    idle(2 * FR);
    write_frame(16'h0000, 4'hF, 1'b1);
    idle(2 * FR);

    write_frame(16'hAAAA, 4'hF, 1'b0);
    write_frame(16'hBBBB, 4'hF, 1'b0);
    idle(2 * FR);

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(325);
    chk("fd_count", fd_cnt, 10);

    for (int i = 0; i < 25; i++) begin
      idle($urandom_range(0, 40));
      write_frame(16'($urandom),
                  ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom),
                  1'($urandom));
    end
    idle(2 * FR);

    // Reset in the middle of a slot while a frame waits in the shadow.
    idle(FR - 5);
    write_frame(16'h1234, 4'hF, 1'b0);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3 * FR);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
